// File: rtl/pmp_cfg_regfile_pkg.sv
// Shared types for the PMP configuration register file: region config layout, PMP modes,
// CSR bit positions of the packed cfg byte, and the clear-sequencer states.
package pmp_cfg_regfile_pkg;

  typedef enum logic [1:0] {
    PMP_MODE_OFF   = 2'd0,
    PMP_MODE_TOR   = 2'd1,
    PMP_MODE_NA4   = 2'd2,
    PMP_MODE_NAPOT = 2'd3
  } pmp_mode_e;

  typedef struct packed {
    logic      lock;
    pmp_mode_e mode;
    logic      exec;
    logic      write;
    logic      read;
  } pmp_cfg_t;

  localparam int unsigned CfgBitR      = 0;
  localparam int unsigned CfgBitW      = 1;
  localparam int unsigned CfgBitX      = 2;
  localparam int unsigned CfgBitModeLo = 3;
  localparam int unsigned CfgBitL      = 7;

  typedef enum logic {
    CLR_IDLE,
    CLR_ACTIVE
  } clr_state_e;

  // W without R is a reserved combination; it is stored as W = 0.
  function automatic pmp_cfg_t cfg_from_csr(input logic [7:0] w);
    pmp_cfg_t c;
    c.read  = w[CfgBitR];
    c.write = w[CfgBitW] & w[CfgBitR];
    c.exec  = w[CfgBitX];
    c.mode  = pmp_mode_e'(w[CfgBitModeLo +: 2]);
    c.lock  = w[CfgBitL];
    return c;
  endfunction

  function automatic logic [7:0] cfg_to_csr(input pmp_cfg_t c);
    logic [7:0] w;
    w                     = '0;
    w[CfgBitR]            = c.read;
    w[CfgBitW]            = c.write;
    w[CfgBitX]            = c.exec;
    w[CfgBitModeLo +: 2]  = c.mode;
    w[CfgBitL]            = c.lock;
    return w;
  endfunction

endpackage

// File: rtl/pmp_cfg_regfile_if.sv
// CSR request/ack port of the PMP register file: single-cycle request, response one cycle later.
interface pmp_csr_if #(
  parameter int IdxW  = 2,
  parameter int DataW = 32
);
  logic             req;
  logic             we;
  logic             sel;
  logic [IdxW-1:0]  idx;
  logic [DataW-1:0] wdata;
  logic             ack;
  logic             err;
  logic [DataW-1:0] rdata;

  modport master (output req, we, sel, idx, wdata, input ack, err, rdata);
  modport slave  (input req, we, sel, idx, wdata, output ack, err, rdata);
endinterface

// File: rtl/pmp_cfg_regfile_clr_fsm.sv
// Clear sequencer: walks regions 0..NumRegions-1, one per cycle, after a start pulse.
// busy is high for exactly NumRegions cycles; start is ignored while busy.
module pmp_clr_fsm
  import pmp_cfg_regfile_pkg::*;
#(
  parameter int NumRegions = 4,
  parameter int IdxW       = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            clr_vld,
  output logic [IdxW-1:0] clr_idx
);

  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumRegions - 1);

  clr_state_e      state_q, state_d;
  logic [IdxW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLR_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy    = 1'b0;
    clr_vld = 1'b0;
    case (state_q)
      CLR_IDLE: begin
        if (start) begin
          state_d = CLR_ACTIVE;
          cnt_d   = '0;
        end
      end
      CLR_ACTIVE: begin
        busy    = 1'b1;
        clr_vld = 1'b1;
        if (cnt_q == LastIdx) begin
          state_d = CLR_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + IdxW'(1);
        end
      end
      default: state_d = CLR_IDLE;
    endcase
  end

  assign clr_idx = cnt_q;

endmodule

// File: rtl/pmp_cfg_regfile.sv
// PMP cfg/addr register file with lock/TOR-lock enforcement and a sequenced clear.
// Optional PMP_CFG_PARITY_EN adds even parity per stored word and a sticky pmp_parity_err.
module pmp_cfg_regfile
  import pmp_cfg_regfile_pkg::*;
#(
  parameter bit PMPEnable     = 1'b1,
  parameter int PMPNumRegions = 4,
  parameter int PMPAddrWidth  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  pmp_csr_if.slave                csr,
  input  logic                    clr_req,
  output logic                    clr_busy,
  output pmp_cfg_t                pmp_cfg  [PMPNumRegions],
  output logic [PMPAddrWidth-1:0] pmp_addr [PMPNumRegions]
`ifdef PMP_CFG_PARITY_EN
  ,
  output logic                    pmp_parity_err
`endif
);

  localparam int RegIdxW = (PMPNumRegions > 1) ? $clog2(PMPNumRegions) : 1;
  localparam int IdxExtW = RegIdxW + 1;

  logic                    req_err;
  logic [PMPAddrWidth-1:0] rd_val;

  if (PMPEnable) begin : gen_en
    pmp_cfg_t                 cfg_q  [PMPNumRegions];
    logic [PMPAddrWidth-1:0]  addr_q [PMPNumRegions];
    logic [PMPNumRegions-1:0] addr_lock, cfg_we, addr_we, cfg_clr, addr_clr;
    logic                     clr_vld;
    logic [RegIdxW-1:0]       clr_idx;
    logic                     idx_bad, lock_hit, clr_start, wr_cfg, wr_addr;
    pmp_cfg_t                 cfg_wr;

    pmp_clr_fsm #(
      .NumRegions (PMPNumRegions),
      .IdxW       (RegIdxW)
    ) u_clr_fsm (
      .clk     (clk),
      .rst     (rst),
      .start   (clr_req),
      .busy    (clr_busy),
      .clr_vld (clr_vld),
      .clr_idx (clr_idx)
    );

    // A TOR region above borrows this region's address as its base, so its lock covers addr[g].
    for (genvar g = 0; g < PMPNumRegions; g++) begin : g_region
      if (g + 1 < PMPNumRegions) begin : g_tor
        assign addr_lock[g] = cfg_q[g].lock |
                              (cfg_q[g+1].lock & (cfg_q[g+1].mode == PMP_MODE_TOR));
      end else begin : g_top
        assign addr_lock[g] = cfg_q[g].lock;
      end
      assign cfg_we[g]   = wr_cfg  & (csr.idx == RegIdxW'(g));
      assign addr_we[g]  = wr_addr & (csr.idx == RegIdxW'(g));
      assign cfg_clr[g]  = clr_vld & (clr_idx == RegIdxW'(g)) & ~cfg_q[g].lock;
      assign addr_clr[g] = cfg_clr[g] & ~addr_lock[g];
    end

    assign idx_bad   = {1'b0, csr.idx} >= IdxExtW'(PMPNumRegions);
    assign lock_hit  = csr.we & (csr.sel ? addr_lock[csr.idx] : cfg_q[csr.idx].lock);
    assign clr_start = clr_req & ~clr_busy;
    assign req_err   = idx_bad | lock_hit | clr_busy | clr_start;
    assign wr_cfg    = csr.req & csr.we & ~csr.sel & ~req_err;
    assign wr_addr   = csr.req & csr.we &  csr.sel & ~req_err;
    assign cfg_wr    = cfg_from_csr(csr.wdata[7:0]);

    always_comb begin
      rd_val = '0;
      if (csr.sel) begin
        rd_val = addr_q[csr.idx];
      end else begin
        rd_val[7:0] = cfg_to_csr(cfg_q[csr.idx]);
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < PMPNumRegions; i++) begin
          cfg_q[i]  <= '0;
          addr_q[i] <= '0;
        end
      end else begin
        for (int i = 0; i < PMPNumRegions; i++) begin
          if (cfg_we[i]) begin
            cfg_q[i] <= cfg_wr;
          end else if (cfg_clr[i]) begin
            cfg_q[i] <= '0;
          end
          if (addr_we[i]) begin
            addr_q[i] <= csr.wdata;
          end else if (addr_clr[i]) begin
            addr_q[i] <= '0;
          end
        end
      end
    end

    assign pmp_cfg  = cfg_q;
    assign pmp_addr = addr_q;

`ifdef PMP_CFG_PARITY_EN
    logic [PMPNumRegions-1:0] cfg_par_q, addr_par_q;
    logic                     par_mismatch, par_err_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cfg_par_q  <= '0;
        addr_par_q <= '0;
      end else begin
        for (int i = 0; i < PMPNumRegions; i++) begin
          if (cfg_we[i]) begin
            cfg_par_q[i] <= ^cfg_wr;
          end else if (cfg_clr[i]) begin
            cfg_par_q[i] <= 1'b0;
          end
          if (addr_we[i]) begin
            addr_par_q[i] <= ^csr.wdata;
          end else if (addr_clr[i]) begin
            addr_par_q[i] <= 1'b0;
          end
        end
      end
    end

    always_comb begin
      par_mismatch = 1'b0;
      for (int i = 0; i < PMPNumRegions; i++) begin
        par_mismatch = par_mismatch | (^{cfg_q[i], cfg_par_q[i]}) |
                       (^{addr_q[i], addr_par_q[i]});
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        par_err_q <= 1'b0;
      end else begin
        par_err_q <= par_err_q | par_mismatch;
      end
    end

    assign pmp_parity_err = par_err_q;
`endif
  end else begin : gen_dis
    logic unused_inputs;

    assign req_err       = 1'b1;
    assign rd_val        = '0;
    assign clr_busy      = 1'b0;
    assign pmp_cfg       = '{default: '0};
    assign pmp_addr      = '{default: '0};
    assign unused_inputs = ^{clr_req, csr.we, csr.sel, csr.idx, csr.wdata};
`ifdef PMP_CFG_PARITY_EN
    assign pmp_parity_err = 1'b0;
`endif
  end

  // Every request is answered next cycle; an error answer never carries data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csr.ack   <= 1'b0;
      csr.err   <= 1'b0;
      csr.rdata <= '0;
    end else begin
      csr.ack   <= csr.req;
      csr.err   <= csr.req & req_err;
      csr.rdata <= (csr.req & ~req_err & ~csr.we) ? rd_val : '0;
    end
  end

endmodule

// File: doc/pmp_cfg_regfile.md
Name: pmp_cfg_regfile

Overview:
- Parametrised PMP configuration/address register file for the ibex-style core; successor to the fixed two-region, cfg-only PMP register array.
- Holds per-region pmp_cfg_t (lock, mode, exec, write, read) and address registers behind a one-cycle CSR request/ack port.
- Enforces lock and TOR-lock rules, and provides a sequenced clear of unlocked regions.
- Outputs feed the PMP checker combinationally.

Parameters:
- PMPEnable, 1: 0 removes all storage (generate-if); outputs tie to zero.
- PMPNumRegions, 4: region count, 1..16.
- PMPAddrWidth, 32: address register width, 8..34.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- csr_req_i  in  1  access request, single-cycle pulse
- csr_we_i  in  1  1 = write, 0 = read
- csr_sel_i  in  1  0 = cfg, 1 = addr
- csr_idx_i  in  RegIdxW  region index
- csr_wdata_i  in  PMPAddrWidth  write data
- csr_ack_o  out  1  access complete
- csr_err_o  out  1  access rejected; valid with ack
- csr_rdata_o  out  PMPAddrWidth  read data; valid with ack
- clr_req_i  in  1  start clear sequence
- clr_busy_o  out  1  clear in progress
- pmp_cfg_o  out  pmp_cfg_t[PMPNumRegions]  region configs
- pmp_addr_o  out  PMPAddrWidth[PMPNumRegions]  region addresses

Behaviour:
- Reset: all cfg/addr = 0, ack = 0, err = 0, rdata = 0, busy = 0, FSM = IDLE.
- Access latency:
  - A csr_req_i accepted in cycle N gives ack = 1 for exactly one cycle in N+1.
  - Register update is visible on the outputs in N+1.
  - No back-pressure.
- cfg write packing (zero-extended to PMPAddrWidth):
  - wdata bits: [0] R, [1] W, [2] X, [4:3] mode, [7] L.
  - Other bits are ignored on write and read as 0.
- WARL rule: on write, W = 1 with R = 0 stores W = 0. All other fields store as written.
- Effective lock of region i: cfg[i].lock, OR (i+1 < N and cfg[i+1].lock and cfg[i+1].mode == TOR). The OR term applies to addr[i] only.
- Error cases: err = 1, no state change.
  - csr_idx_i >= PMPNumRegions.
  - Write to a locked cfg or effectively locked addr.
  - Request while clr_busy_o = 1.
  - Request in the same cycle as an accepted clr_req_i.
  - Any request when PMPEnable = 0.
- Reads of any valid index return stored data with err = 0. On error, rdata = 0.
- Lock is sticky: it is cleared only by rst_i. Clear and writes never clear it.
- Clear FSM:
  - IDLE → CLEAR on clr_req_i; cnt = 0.
  - In CLEAR: each cycle, if region cnt is unlocked, zero cfg[cnt] and addr[cnt]; then cnt++.
  - CLEAR → IDLE after cnt = N-1.
  - busy = 1 for exactly N cycles, starting the cycle after the request.
  - addr[cnt] under TOR-lock is kept; its unlocked cfg is still cleared.
  - clr_req_i while in CLEAR is ignored.
- rst_i asserted mid-clear or mid-access: immediate return to the reset state; a pending ack is dropped.

Optional Feature:
- PMP_CFG_PARITY_EN: each cfg and addr register stores an even-parity bit, computed on write or clear.
  - Adds output pmp_parity_err_o (1 bit).
  - pmp_parity_err_o is registered and asserts the cycle after any stored word mismatches its parity.
  - It is sticky until reset.
- Without the macro: no parity storage and no port.

Decomposition:
- ibex_pkg: extended pmp_cfg_t (lock, mode[1:0], exec, write, read), pmp_mode_e (OFF = 0, TOR = 1, NA4 = 2, NAPOT = 3), cfg bit-position constants.
- Top module: RegIdxW = max(1, $clog2(PMPNumRegions)) as a localparam.
- One sub-module, pmp_clr_fsm: IDLE/CLEAR state, counter, busy output, and clear index/strobe to the register array.

Test Plan:
- Write cfg idx 1 = 0x0B (R, W, TOR) → ack next cycle, err = 0; read returns 0x0B; pmp_cfg_o[1] = {L0, TOR, X0, W1, R1}.
- Write cfg idx 0 = 0x02 (W without R) → stored value reads 0x00.
- Write cfg idx 2 = 0x89 (L, TOR, R), then write addr idx 1 and addr idx 2 = 0x1234 → both err = 1; addr unchanged. Addr idx 3 writes OK.
- Write to idx = PMPNumRegions → err = 1, rdata = 0. Read with PMPEnable = 0 → err = 1.
- N = 4, region 2 locked: pulse clr_req_i → busy for 4 cycles; regions 0, 1, 3 zeroed; region 2 cfg retained; addr[1] cleared unless region 2 mode is TOR. CSR request during busy → err = 1.
- Assert rst_i in the 2nd clear cycle → all outputs 0 next edge, busy = 0. Under PMP_CFG_PARITY_EN, force a bit flip → pmp_parity_err_o = 1 next cycle, held until reset.
